bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Loadable 8-digit BCD down-counter; the countdown counterpart of the team's 8-digit BCD up-counting seconds timer. Advances on the same single-cycle one_sec strobe. Digit outputs use the same per-digit 4-bit format, so the existing display path consumes them unchanged. Provides start/pause control, an expiry flag and a done pulse for the surrounding control logic.

Parameters:
AUTO_RELOAD, 0, 1 = on expiry reload the last loaded value and keep running; 0 = stop at zero
NUM_DIGITS, 8, fixed digit count; documentation only, not overridable

Ports:
clk        input   1   system clock
reset      input   1   asynchronous, active-low reset
one_sec    input   1   single-cycle tick strobe, synchronous to clk
load       input   1   capture load_d into the count and the reload register
load_d     input   32  packed BCD preset; [3:0] = digit 0 (LSD) … [31:28] = digit 7
start      input   1   start or resume countdown
pause      input   1   suspend countdown
cnt_d0..cnt_d7  output  4 each  current BCD digits; d0 = LSD
running    output  1   high while state == RUN
expired    output  1   high while state == EXPIRED
done       output  1   one-cycle pulse on the expiry event
load_err   output  1   one-cycle pulse when load_d contained a non-BCD nibble

Behaviour:
- Reset (asynchronous, active-low) forces the following, and applies even mid-count:
  - all digits = 0, reload register = 0
  - state = IDLE
  - running = 0, expired = 0, done = 0, load_err = 0
- All outputs are registered. done and load_err are high for exactly one cycle; otherwise 0.
- States:
  - IDLE: loaded, not counting.
  - RUN: counting down.
  - PAUSE: suspended.
  - EXPIRED: reached zero.
- Priority within a cycle: load > pause > start > one_sec.
- load, in any state:
  - digits <= load_d and reload register <= load_d; state -> IDLE.
  - Any nibble > 9 is clamped to 9 in both the digits and the reload register; load_err pulses on the next edge.
  - A one_sec in the same cycle is ignored.
- start, in IDLE or PAUSE:
  - count nonzero -> RUN.
  - count zero -> EXPIRED, with done pulsing.
- start in EXPIRED:
  - reload register nonzero -> digits <= reload register, state -> RUN.
  - reload register zero -> stay EXPIRED.
- start in RUN: no effect.
- pause in RUN -> PAUSE. pause in any other state: no effect. pause and start together: pause wins.
- one_sec in RUN, count > 1: BCD decrement with borrow chain.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - Example: 00001000 -> 00000999.
  - The result takes effect at the edge where one_sec is sampled high (latency 1 clock).
- one_sec in RUN, count == 00000001 (expiry event):
  - AUTO_RELOAD = 0: digits -> 0, state -> EXPIRED, done pulses on the same edge.
  - AUTO_RELOAD = 1: digits -> reload register, stay RUN, done pulses. Period is N ticks; zero is never displayed.
- one_sec in IDLE, PAUSE or EXPIRED is ignored; digits hold.
- Digit 7 never borrows out: count 00000000 is never decremented in RUN, so no wrap to 99999999 is possible.

Decomposition:
- Package bcd_timer_pkg:
  - state enum (IDLE, RUN, PAUSE, EXPIRED)
  - BCD_NINE = 4'd9, BCD_ZERO = 4'd0, NUM_DIGITS = 8
  - function clamping a nibble to 9
- Sub-module bcd_digit_dec: combinational single-digit decrement.
  - Inputs: 4-bit digit, borrow_in.
  - Outputs: next digit, borrow_out (asserted when digit == 0 and borrow_in).
  - Instantiated 8 times as a ripple chain; digit 0 borrow_in = decrement enable.
- Zero-detect and "count == 1" detect live in the top level.

Test Plan:
1. Load 00000003, start, 3 one_sec ticks -> digits 2, 1, 0. done pulses exactly one cycle on the third tick edge, then expired = 1, running = 0. Two further ticks -> digits stay 0, no further done.
2. Load 00001000, start, one tick -> 00000999. Load 10000000, one tick -> 09999999 (full borrow chain).
3. Load 00000010, start, 2 ticks -> 08. Pause, 5 ticks -> holds 08, running = 0. Start, 1 tick -> 07. Pause and start in the same cycle while in RUN -> PAUSE.
4. Load with d2 nibble = 0xC -> cnt_d2 = 9 and load_err pulses once. While RUN at 00000050, assert load = 00000020 together with one_sec -> digits 00000020, state IDLE, no decrement.
5. Reset asserted mid-RUN at 00000500 -> all digits 0, IDLE, all flags 0 immediately, without waiting for clk. After release, start with zero count -> done pulse, expired = 1.
6. AUTO_RELOAD = 1: load 00000002, start, 4 ticks -> 1, 2 (done), 1, 2 (done). running stays 1 throughout. Start in EXPIRED (AUTO_RELOAD = 0 build) after load 5 expiry -> digits 5, RUN.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared states, BCD constants and nibble clamp for the BCD countdown timer
package bcd_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam int NUM_DIGITS = 8;
  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > BCD_NINE) ? BCD_NINE : n;
  endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: combinational single BCD digit decrement with borrow
module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_n,
  output logic       borrow_out
);
  assign borrow_out = borrow_in && (digit == BCD_ZERO);
  assign digit_n = !borrow_in ? digit : (digit == BCD_ZERO) ? BCD_NINE : digit - 4'd1;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: loadable 8-digit BCD down-counter on the one_sec strobe
// with start/pause control, expiry flag, done pulse and optional auto-reload.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter logic AUTO_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_sec,
  input  logic        load,
  input  logic [31:0] load_d,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  cnt_d0,
  output logic [3:0]  cnt_d1,
  output logic [3:0]  cnt_d2,
  output logic [3:0]  cnt_d3,
  output logic [3:0]  cnt_d4,
  output logic [3:0]  cnt_d5,
  output logic [3:0]  cnt_d6,
  output logic [3:0]  cnt_d7,
  output logic        running,
  output logic        expired,
  output logic        done,
  output logic        load_err
);
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, rel, rel_n, lv, dec;
  logic [NUM_DIGITS:0] b;
  logic done_n, err_n, bad, is_zero, is_one;
  assign is_zero = (cnt == '0);
  assign is_one = (cnt == 32'h0000_0001);
  assign b[0] = one_sec && (state == RUN);
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit(cnt[4*g +: 4]),
      .borrow_in(b[g]),
      .digit_n(dec[4*g +: 4]),
      .borrow_out(b[g+1])
    );
  end
  always_comb begin
    bad = 1'b0;
    lv = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lv[4*i +: 4] = clamp9(load_d[4*i +: 4]);
      bad = bad | (load_d[4*i +: 4] > BCD_NINE);
    end
  end
  // Priority: load > pause > start > one_sec; start in RUN falls through to the tick.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rel_n = rel;
    done_n = 1'b0;
    err_n = 1'b0;
    if (load) begin
      cnt_n = lv;
      rel_n = lv;
      state_n = IDLE;
      err_n = bad;
    end else if (pause) begin
      state_n = (state == RUN) ? PAUSE : state;
    end else if (start && state != RUN) begin
      if (state == EXPIRED) begin
        cnt_n = (rel != '0) ? rel : cnt;
        state_n = (rel != '0) ? RUN : EXPIRED;
      end else begin
        state_n = is_zero ? EXPIRED : RUN;
        done_n = is_zero;
      end
    end else if (b[0]) begin
      if (is_one) begin
        done_n = 1'b1;
        cnt_n = AUTO_RELOAD ? rel : '0;
        state_n = AUTO_RELOAD ? RUN : EXPIRED;
      end else if (!b[NUM_DIGITS]) begin
        cnt_n = dec;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rel <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rel <= rel_n;
      running <= (state_n == RUN);
      expired <= (state_n == EXPIRED);
      done <= done_n;
      load_err <= err_n;
    end
  end
  assign cnt_d0 = cnt[3:0];
  assign cnt_d1 = cnt[7:4];
  assign cnt_d2 = cnt[11:8];
  assign cnt_d3 = cnt[15:12];
  assign cnt_d4 = cnt[19:16];
  assign cnt_d5 = cnt[23:20];
  assign cnt_d6 = cnt[27:24];
  assign cnt_d7 = cnt[31:28];
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: scoreboard bench comparing a stop-at-zero and an auto-reload
// instance against a decimal-arithmetic reference model.
module tb_bcd_countdown_timer;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  typedef struct {int cnt; int rel; int st; bit done; bit err;} mdl_t;
  typedef struct packed {logic [31:0] bcd; logic run; logic exp; logic done; logic err;} obs_t;
  logic clk = 0, reset = 0, one_sec = 0, load = 0, start = 0, pause = 0;
  logic [31:0] load_d = '0;
  logic [3:0] a0, a1, a2, a3, a4, a5, a6, a7, b0, b1, b2, b3, b4, b5, b6, b7;
  logic run_a, exp_a, done_a, err_a, run_b, exp_b, done_b, err_b;
  obs_t got_a, got_b;
  mdl_t m0, m1;
  obs_t q0[$], q1[$];
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  bcd_countdown_timer #(.AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .reset(reset), .one_sec(one_sec), .load(load), .load_d(load_d),
    .start(start), .pause(pause),
    .cnt_d0(a0), .cnt_d1(a1), .cnt_d2(a2), .cnt_d3(a3),
    .cnt_d4(a4), .cnt_d5(a5), .cnt_d6(a6), .cnt_d7(a7),
    .running(run_a), .expired(exp_a), .done(done_a), .load_err(err_a));
  bcd_countdown_timer #(.AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .reset(reset), .one_sec(one_sec), .load(load), .load_d(load_d),
    .start(start), .pause(pause),
    .cnt_d0(b0), .cnt_d1(b1), .cnt_d2(b2), .cnt_d3(b3),
    .cnt_d4(b4), .cnt_d5(b5), .cnt_d6(b6), .cnt_d7(b7),
    .running(run_b), .expired(exp_b), .done(done_b), .load_err(err_b));
  assign got_a = {a7, a6, a5, a4, a3, a2, a1, a0, run_a, exp_a, done_a, err_a};
  assign got_b = {b7, b6, b5, b4, b3, b2, b1, b0, run_b, exp_b, done_b, err_b};
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic obs_t snap(input mdl_t x);
    return {to_bcd(x.cnt), x.st == S_RUN, x.st == S_EXP, x.done, x.err};
  endfunction
  function automatic mdl_t model(input mdl_t x, input bit ar, input bit ld, input logic [31:0] d,
                                 input bit s, input bit p, input bit t);
    mdl_t y;
    int v, n;
    bit bad;
    y = x;
    y.done = 0;
    y.err = 0;
    if (ld) begin
      v = 0;
      bad = 0;
      for (int i = 7; i >= 0; i--) begin
        n = int'(d[4*i +: 4]);
        if (n > 9) begin bad = 1; n = 9; end
        v = v * 10 + n;
      end
      y.cnt = v;
      y.rel = v;
      y.st = S_IDLE;
      y.err = bad;
    end else if (p) begin
      if (x.st == S_RUN) y.st = S_PAUSE;
    end else if (s && x.st != S_RUN) begin
      if (x.st == S_EXP) begin
        if (x.rel != 0) begin y.cnt = x.rel; y.st = S_RUN; end
      end else if (x.cnt == 0) begin
        y.st = S_EXP;
        y.done = 1;
      end else y.st = S_RUN;
    end else if (t && x.st == S_RUN) begin
      if (x.cnt == 1) begin
        y.done = 1;
        y.cnt = ar ? x.rel : 0;
        y.st = ar ? S_RUN : S_EXP;
      end else if (x.cnt > 1) y.cnt = x.cnt - 1;
    end
    return y;
  endfunction
  task automatic step(input bit ld, input logic [31:0] d, input bit s, input bit p, input bit t);
    @(negedge clk);
    load = ld; load_d = d; start = s; pause = p; one_sec = t;
    m0 = model(m0, 0, ld, d, s, p, t);
    m1 = model(m1, 1, ld, d, s, p, t);
    q0.push_back(snap(m0));
    q1.push_back(snap(m1));
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask
  task automatic check_now(input string name, input obs_t got, input obs_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) check_now("sb_stop", got_a, q0.pop_front());
    if (q1.size() > 0) check_now("sb_reload", got_b, q1.pop_front());
  end
  initial begin
    m0 = '{0, 0, S_IDLE, 0, 0};
    m1 = m0;
    #12;
    check_now("reset_a", got_a, '0);
    check_now("reset_b", got_b, '0);
    @(negedge clk);
    reset = 1;
    step(1, 32'h3, 0, 0, 0); step(0, 0, 1, 0, 0); ticks(5);
    step(1, 32'h1000, 0, 0, 0); step(0, 0, 1, 0, 0); ticks(1);
    step(1, 32'h1000_0000, 0, 0, 0); step(0, 0, 1, 0, 0); ticks(1);
    step(1, 32'h10, 0, 0, 0); step(0, 0, 1, 0, 0); ticks(2);
    step(0, 0, 0, 1, 0); ticks(5); step(0, 0, 1, 0, 0); ticks(1);
    step(0, 0, 1, 1, 0); ticks(1);
    step(1, 32'h0000_0C00, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 32'h50, 0, 0, 0); step(0, 0, 1, 0, 0);
    step(1, 32'h20, 0, 0, 1); ticks(1);
    step(1, 32'h2, 0, 0, 0); step(0, 0, 1, 0, 0); ticks(4);
    step(1, 32'h5, 0, 0, 0); step(0, 0, 1, 0, 0); ticks(5);
    step(0, 0, 1, 0, 0); ticks(2);
    step(1, 32'h500, 0, 0, 0); step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0);
    @(negedge clk);
    #2 reset = 0;
    #1;
    check_now("async_reset_a", got_a, '0);
    check_now("async_reset_b", got_b, '0);
    m0 = '{0, 0, S_IDLE, 0, 0};
    m1 = m0;
    @(negedge clk);
    reset = 1;
    step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? $urandom : to_bcd($urandom_range(0, 25));
      step($urandom_range(0, 19) == 0, d, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
    end
    step(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    compared++;
    if (q0.size() + q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain got=%0d want=0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
